// File: rtl/k_param_register_file.sv
// -----------------------------------------------------------------------------
// k_param_register_file
//
// Parametrised multi-read-port, single-write-port register file for the
// decode stage. Read data is registered (one-cycle latency). After reset, or
// when K_clear is pulsed, an init sequencer sweeps every entry to a known
// value and raises K_busy while it runs; user reads return 0 and user writes
// are dropped during the sweep.
//
// Optional feature macro: K_REGFILE_BYPASS_EN
//   defined   : a read of the address being written on the same edge returns
//               the new write data (write-first).
//   undefined : such a read returns the old entry contents (read-first).
//   Dropped writes are never forwarded in either build.
//
// Parameters
//   DATA_W    data width of each entry
//   ADDR_W    address width
//   DEPTH     number of entries, DEPTH <= 2**ADDR_W
//   NUM_RD    number of read ports (>= 1)
//   ZERO_REG  1: entry 0 reads as 0 and writes to it are dropped
//   INIT_MODE sweep value: 0 -> entry i gets i, 1 -> entry i gets 0
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   asynchronous reset, active-high
//   K_rd_addr     in   read addresses, port p = [p*ADDR_W +: ADDR_W]
//   K_rd_en       in   per-port read enable (0: output holds)
//   K_rd_data     out  registered read data, port p = [p*DATA_W +: DATA_W]
//   K_Regwrite    in   write enable
//   K_wr_addr     in   write address
//   K_write_data  in   write data
//   K_clear       in   one-cycle pulse: restart the init sweep
//   K_busy        out  sweep in progress
// -----------------------------------------------------------------------------
module k_param_register_file #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int DEPTH     = 32,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1,
   parameter int INIT_MODE = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   K_rd_addr,
   input  logic [NUM_RD-1:0]          K_rd_en,
   output logic [NUM_RD*DATA_W-1:0]   K_rd_data,
   input  logic                       K_Regwrite,
   input  logic [ADDR_W-1:0]          K_wr_addr,
   input  logic [DATA_W-1:0]          K_write_data,
   input  logic                       K_clear,
   output logic                       K_busy
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          ptr_q, ptr_d;
   logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [DATA_W-1:0]          mem_q [DEPTH];
   logic [DATA_W-1:0]          mem_d [DEPTH];

   logic                       mem_we;
   logic [ADDR_W-1:0]          mem_waddr;
   logic [DATA_W-1:0]          mem_wdata;
   logic                       wr_accept;
   logic                       sweep_last;
   logic [DATA_W-1:0]          init_val;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return int'(a) < DEPTH;
   endfunction

   // An address is backed by real storage unless it is out of range or the
   // hard-wired zero register.
   function automatic logic addr_backed(input logic [ADDR_W-1:0] a);
      return addr_in_range(a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // A user write lands only in IDLE, only without a concurrent clear, and
   // only to a backed entry. The same qualifier gates forwarding, so a
   // dropped write can never be bypassed to a reader.
   assign wr_accept  = (state_q == ST_IDLE) && K_Regwrite && !K_clear &&
                       addr_backed(K_wr_addr);
   assign sweep_last = (int'(ptr_q) == DEPTH - 1);
   // Static cast zero-extends or truncates ptr to DATA_W as needed.
   assign init_val   = (INIT_MODE == 0) ? DATA_W'(ptr_q) : '0;

   // --------------------------------------------------------------------------
   // FSM process 1: state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_INIT;
         ptr_q     <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

   // NOTE: the storage array has no reset; the init sweep defines its
   // contents, and leaving it unreset lets it map onto plain flops or RAM.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   // --------------------------------------------------------------------------
   // FSM process 2: next state and sweep pointer
   // --------------------------------------------------------------------------
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_INIT: begin
            if (K_clear) begin
               ptr_d = '0;
            end else if (sweep_last) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (K_clear) begin
               state_d = ST_INIT;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM process 3: outputs (busy flag and array write port)
   // --------------------------------------------------------------------------
   always_comb begin
      K_busy    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = K_wr_addr;
      mem_wdata = K_write_data;
      case (state_q)
         ST_INIT: begin
            K_busy    = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = init_val;
         end
         ST_IDLE: begin
            mem_we = wr_accept;
         end
         default: begin
            K_busy = 1'b1;
         end
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (mem_we) begin
         mem_d[mem_waddr] = mem_wdata;
      end
   end

   // --------------------------------------------------------------------------
   // Read ports
   // --------------------------------------------------------------------------
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rv;
      rd_data_d = rd_data_q;
      ra        = '0;
      rv        = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         ra = K_rd_addr[p*ADDR_W +: ADDR_W];
         rv = '0;
         if (addr_backed(ra)) begin
`ifdef K_REGFILE_BYPASS_EN
            if (wr_accept && (ra == K_wr_addr)) begin
               rv = K_write_data;
            end else begin
               rv = mem_q[ra];
            end
`else
            rv = mem_q[ra];
`endif
         end
         if (state_q == ST_INIT) begin
            rd_data_d[p*DATA_W +: DATA_W] = '0;
         end else if (K_rd_en[p]) begin
            rd_data_d[p*DATA_W +: DATA_W] = rv;
         end
      end
   end

   assign K_rd_data = rd_data_q;

endmodule
